paralelo_serial_tx: RTL and testbench



---
 rtl/paralelo_serial_tx_pkg.sv | 18 +
 rtl/paralelo_serial_tx_if.sv | 27 ++
 rtl/paralelo_serial_tx_hold_reg.sv | 55 +++++
 rtl/paralelo_serial_tx.sv | 128 ++++++++++++
 tb/tb_paralelo_serial_tx.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/paralelo_serial_tx_pkg.sv
// -----------------------------------------------------------------------------
// paralelo_serial_tx_pkg
// Symbols and types shared by the serial lane transmitter and receiver.
//   COMMA_SYM   : idle / alignment symbol placed on the lane
//   SYNC_FRAMES : number of COMMA frames sent after reset before data may flow
//   ps_state_e  : transmitter phase (SYNC after reset, RUN once aligned)
// -----------------------------------------------------------------------------
package paralelo_serial_tx_pkg;

    localparam logic [7:0] COMMA_SYM   = 8'hBC;
    localparam int         SYNC_FRAMES = 4;

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } ps_state_e;

endpackage : paralelo_serial_tx_pkg

// File: rtl/paralelo_serial_tx_if.sv
// -----------------------------------------------------------------------------
// paralelo_serial_tx_if
// Byte-wide valid/ready channel into the serial transmitter.
//   data_in_PS : byte offered by the source
//   valid_PS   : data_in_PS is valid
//   ready_PS   : transmitter can take a byte this cycle
// Modports: master = byte source, slave = transmitter.
// -----------------------------------------------------------------------------
interface paralelo_serial_tx_if;

    logic [7:0] data_in_PS;
    logic       valid_PS;
    logic       ready_PS;

    modport master (
        output data_in_PS,
        output valid_PS,
        input  ready_PS
    );

    modport slave (
        input  data_in_PS,
        input  valid_PS,
        output ready_PS
    );

endinterface : paralelo_serial_tx_if

// File: rtl/paralelo_serial_tx_hold_reg.sv
// -----------------------------------------------------------------------------
// ps_hold_reg
// One-entry valid/ready holding register between the byte source and the
// serialiser.
//   clk_32f, reset_L : bit clock, asynchronous active-low reset
//   data_in, valid   : byte offered by the source
//   ready            : register empty (combinational from hold_full)
//   drop             : accepted byte is consumed without being stored
//   unload           : serialiser took the held byte this edge
//   hold, hold_full  : stored byte and its occupancy flag
//   comma_drop       : one-cycle pulse after a byte was consumed via drop
// -----------------------------------------------------------------------------
module ps_hold_reg (
    input  logic       clk_32f,
    input  logic       reset_L,
    input  logic [7:0] data_in,
    input  logic       valid,
    output logic       ready,
    input  logic       drop,
    input  logic       unload,
    output logic [7:0] hold,
    output logic       hold_full,
    output logic       comma_drop
);

    logic accept;
    logic store;

    // ready depends only on hold_full, so an accept (hold empty) and an
    // unload (hold full) can never land on the same edge.
    assign ready  = ~hold_full;
    assign accept = valid & ~hold_full;
    assign store  = accept & ~drop;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    // NOTE: hold is a single register, not a memory array, so it is reset
    // along with its flag; a byte held at reset must never leak out later.
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            hold       <= '0;
            hold_full  <= 1'b0;
            comma_drop <= 1'b0;
        end else begin
            comma_drop <= accept & drop;
            if (store) begin
                hold      <= data_in;
                hold_full <= 1'b1;
            end else if (unload) begin
                hold_full <= 1'b0;
            end
        end
    end

endmodule : ps_hold_reg

// File: rtl/paralelo_serial_tx.sv
// -----------------------------------------------------------------------------
// paralelo_serial_tx
// Parallel-to-serial lane transmitter, MSB first, one bit per clk_32f cycle.
// After reset it sends SYNC_COUNT COMMA frames so the receiver can align,
// then sends held data bytes, filling idle frame slots with COMMA.
//   clk_32f, reset_L : bit clock, asynchronous active-low reset
//   bus (slave)      : data_in_PS / valid_PS / ready_PS byte handshake
//   data_out_PS      : registered serial bit
//   sync_done        : high once the SYNC burst has completed
//   comma_drop       : one-cycle pulse when an offered COMMA byte is filtered
// Build option: PS_COMMA_FILTER_EN -- accepted bytes equal to COMMA are
// consumed but not transmitted (their slot goes out as idle COMMA). When it
// is undefined such bytes are sent like any data and comma_drop stays 0.
// -----------------------------------------------------------------------------
module paralelo_serial_tx
    import paralelo_serial_tx_pkg::*;
#(
    parameter logic [7:0] COMMA      = COMMA_SYM,
    parameter int         SYNC_COUNT = SYNC_FRAMES
) (
    input  logic                 clk_32f,
    input  logic                 reset_L,
    paralelo_serial_tx_if.slave  bus,
    output logic                 data_out_PS,
    output logic                 sync_done,
    output logic                 comma_drop
);

    localparam int FC_W = $clog2(SYNC_COUNT + 1);

    ps_state_e       state, state_nx;
    logic [FC_W-1:0] frame_cnt, frame_cnt_nx;
    logic            sync_done_nx;
    logic [2:0]      cnt;
    logic [7:0]      shreg;
    logic [7:0]      frame;
    logic [7:0]      hold;
    logic            hold_full;
    logic            unload;
    logic            drop;
    logic            boundary;
    logic            frame_end;

    assign boundary  = (cnt == 3'd0);
    assign frame_end = (cnt == 3'd7);

`ifdef PS_COMMA_FILTER_EN
    assign drop = (bus.data_in_PS == COMMA);
`else
    assign drop = 1'b0;
`endif

    ps_hold_reg u_hold (
        .clk_32f    (clk_32f),
        .reset_L    (reset_L),
        .data_in    (bus.data_in_PS),
        .valid      (bus.valid_PS),
        .ready      (bus.ready_PS),
        .drop       (drop),
        .unload     (unload),
        .hold       (hold),
        .hold_full  (hold_full),
        .comma_drop (comma_drop)
    );

    // FSM state, SYNC frame counter and the sticky sync_done flag.
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            state     <= SYNC;
            frame_cnt <= '0;
            sync_done <= 1'b0;
        end else begin
            state     <= state_nx;
            frame_cnt <= frame_cnt_nx;
            sync_done <= sync_done_nx;
        end
    end

    // Next state and the frame chosen for the next boundary.
    // NOTE: every output gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx     = state;
        frame_cnt_nx = frame_cnt;
        sync_done_nx = sync_done;
        unload       = 1'b0;
        frame        = COMMA;
        case (state)
            SYNC: begin
                if (frame_end) begin
                    frame_cnt_nx = frame_cnt + FC_W'(1);
                    // Last COMMA bit goes out on this edge; RUN takes over at
                    // the following boundary.
                    if (frame_cnt == FC_W'(SYNC_COUNT - 1)) begin
                        state_nx     = RUN;
                        sync_done_nx = 1'b1;
                    end
                end
            end
            RUN: begin
                if (boundary && hold_full) begin
                    frame  = hold;
                    unload = 1'b1;
                end
            end
            default: state_nx = SYNC;
        endcase
    end

    // Bit counter and shift register. At the boundary the MSB of the new
    // frame goes straight to the line; the copy in shreg supplies bits 6..0.
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            cnt         <= 3'd0;
            shreg       <= '0;
            data_out_PS <= 1'b0;
        end else begin
            cnt <= cnt + 3'd1;
            if (boundary) begin
                shreg       <= frame;
                data_out_PS <= frame[7];
            end else begin
                data_out_PS <= shreg[3'd7 - cnt];
            end
        end
    end

endmodule : paralelo_serial_tx

// File: tb/tb_paralelo_serial_tx.sv
// -----------------------------------------------------------------------------
// tb_paralelo_serial_tx
// Self-checking bench for paralelo_serial_tx. The reference model describes
// the line purely by frame arithmetic: edge n after reset carries bit
// (n-1)%8 of frame (n-1)/8; the first SYNC_FRAMES frames are COMMA, later
// frames carry the byte waiting at the frame start, else COMMA.
// Honours PS_COMMA_FILTER_EN when defined.
// -----------------------------------------------------------------------------
module tb_paralelo_serial_tx;
    import paralelo_serial_tx_pkg::*;

    logic clk_32f = 1'b0;
    logic reset_L;
    logic data_out_PS;
    logic sync_done;
    logic comma_drop;

    paralelo_serial_tx_if bus ();

    paralelo_serial_tx dut (
        .clk_32f     (clk_32f),
        .reset_L     (reset_L),
        .bus         (bus.slave),
        .data_out_PS (data_out_PS),
        .sync_done   (sync_done),
        .comma_drop  (comma_drop)
    );

    always #5 clk_32f = ~clk_32f;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state
    int         n;          // rising edges since reset release
    logic [7:0] m_hold;
    bit         m_full;
    logic [7:0] m_frame;
    bit         m_out, m_sync, m_drop;
    bit         last_acc;
    logic       line_bits [0:4095];

    typedef struct {
        logic [7:0] data;
        logic [7:0] exp_frame;
        bit         exp_drop;
        int         idle_before;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d, t=%0t)", name, act, exp, n, $time);
        end
    endtask

    task automatic model_clear();
        n      = 0;
        m_full = 1'b0;
        m_hold = '0;
        m_out  = 1'b0;
        m_sync = 1'b0;
        m_drop = 1'b0;
        last_acc = 1'b0;
    endtask

    task automatic model_edge(input bit v, input logic [7:0] d);
        int k, f;
        bit was_full;
        n++;
        k = (n - 1) % 8;
        f = (n - 1) / 8;
        was_full = m_full;
        if (k == 0) begin
            if (f >= SYNC_FRAMES && m_full) begin
                m_frame = m_hold;
                m_full  = 1'b0;
            end else begin
                m_frame = COMMA_SYM;
            end
        end
        m_out    = m_frame[7 - k];
        m_sync   = (n >= 8 * SYNC_FRAMES);
        m_drop   = 1'b0;
        last_acc = v && !was_full;
        if (last_acc) begin
`ifdef PS_COMMA_FILTER_EN
            if (d == COMMA_SYM) m_drop = 1'b1;
            else begin m_hold = d; m_full = 1'b1; end
`else
            m_hold = d;
            m_full = 1'b1;
`endif
        end
    endtask

    task automatic tick();
        bit         v;
        logic [7:0] d;
        v = bus.valid_PS;
        d = bus.data_in_PS;
        @(posedge clk_32f);
        model_edge(v, d);
        #1;
        if (n < 4096) line_bits[n] = data_out_PS;
        check("data_out_PS", data_out_PS, m_out);
        check("sync_done",   sync_done,   m_sync);
        check("ready_PS",    bus.ready_PS, !m_full);
        check("comma_drop",  comma_drop,  m_drop);
    endtask

    task automatic wait_accept(output int at);
        at = -1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (last_acc) begin
                at = n;
                break;
            end
        end
        if (at < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: got no handshake, expected one within 40 cycles (t=%0t)", $time);
        end
    endtask

    task automatic apply_reset(input int hold_cycles);
        reset_L         = 1'b0;
        bus.valid_PS    = 1'b0;
        bus.data_in_PS  = '0;
        model_clear();
        repeat (hold_cycles) @(posedge clk_32f);
        @(negedge clk_32f);
        reset_L = 1'b1;
    endtask

    function automatic logic [7:0] frame_at(input int s);
        logic [7:0] f;
        f = 'x;
        if (s >= 1 && s + 7 < 4096)
            for (int j = 0; j < 8; j++) f[7 - j] = line_bits[s + j];
        return f;
    endfunction

    // First frame boundary strictly after edge t
    function automatic int next_boundary(input int t);
        return ((t - 1) / 8 + 1) * 8 + 1;
    endfunction

    initial begin
        int a, b, a0, a1, commas;
        int acc [3];
        logic [7:0] b2b [3];

        tbl[0] = '{8'h01, 8'h01, 1'b0, 0};
        tbl[1] = '{8'h5A, 8'h5A, 1'b0, 1};
        tbl[2] = '{8'hA5, 8'hA5, 1'b0, 3};
`ifdef PS_COMMA_FILTER_EN
        tbl[3] = '{8'hBC, 8'hBC, 1'b1, 2};
`else
        tbl[3] = '{8'hBC, 8'hBC, 1'b0, 2};
`endif
        tbl[4] = '{8'h00, 8'h00, 1'b0, 6};
        tbl[5] = '{8'hFE, 8'hFE, 1'b0, 5};
        b2b[0] = 8'h01;
        b2b[1] = 8'h80;
        b2b[2] = 8'hFF;

        // Reset values while reset_L is held low
        reset_L        = 1'b0;
        bus.valid_PS   = 1'b0;
        bus.data_in_PS = '0;
        model_clear();
        #2;
        check("rst_data_out", data_out_PS,  1'b0);
        check("rst_ready",    bus.ready_PS, 1'b1);
        check("rst_sync",     sync_done,    1'b0);
        check("rst_drop",     comma_drop,   1'b0);

        // SYNC burst with no traffic, then idle COMMA
        apply_reset(2);
        repeat (48) tick();
        check("sync_word", {frame_at(1), frame_at(9), frame_at(17), frame_at(25)}, {4{COMMA_SYM}});
        check("idle_frames", {frame_at(33), frame_at(41)}, {2{COMMA_SYM}});

        // Byte offered during SYNC waits in hold until the first RUN boundary
        apply_reset(3);
        tick();
        tick();
        bus.valid_PS   = 1'b1;
        bus.data_in_PS = 8'h5A;
        wait_accept(a);
        bus.valid_PS   = 1'b0;
        check("sync_accept_edge", a, 3);
        while (n < 40) tick();
        check("first_run_frame", frame_at(33), 8'h5A);

        // Table of single bytes in RUN at varying frame alignments
        foreach (tbl[i]) begin
            repeat (tbl[i].idle_before) tick();
            bus.valid_PS   = 1'b1;
            bus.data_in_PS = tbl[i].data;
            wait_accept(a);
            bus.valid_PS   = 1'b0;
            check("tbl_drop", comma_drop, tbl[i].exp_drop);
            if (a > 0) begin
                b = next_boundary(a);
                while (n < b + 7) tick();
                check("tbl_frame", frame_at(b), tbl[i].exp_frame);
            end
        end

        // Back-to-back bytes with valid held high
        repeat (3) tick();
        bus.valid_PS = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.data_in_PS = b2b[i];
            wait_accept(acc[i]);
        end
        bus.valid_PS = 1'b0;
        b = next_boundary(acc[0]);
        while (n < b + 23) tick();
        check("b2b_frames", {frame_at(b), frame_at(b + 8), frame_at(b + 16)}, 24'h0180FF);
        check("b2b_accept_after_unload", acc[1], b + 1);
        check("b2b_accept_spacing", acc[2] - acc[1], 8);

        // Reset mid data frame with a second byte sitting in hold
        repeat (2) tick();
        bus.valid_PS   = 1'b1;
        bus.data_in_PS = 8'hFF;
        wait_accept(a0);
        bus.data_in_PS = 8'h3C;
        wait_accept(a1);
        bus.valid_PS   = 1'b0;
        b = next_boundary(a0);
        while (n < b + 4) tick();
        check("pre_reset_ready", bus.ready_PS, 1'b0);
        check("pre_reset_bit",   data_out_PS,  1'b1);
        #2;
        reset_L = 1'b0;
        #1;
        check("async_rst_data_out", data_out_PS,  1'b0);
        check("async_rst_ready",    bus.ready_PS, 1'b1);
        check("async_rst_sync",     sync_done,    1'b0);
        apply_reset(2);
        repeat (48) tick();
        commas = 0;
        for (int f = 0; f < 6; f++)
            if (frame_at(1 + 8 * f) == COMMA_SYM) commas++;
        check("post_reset_commas", commas, 6);

        // Randomised traffic against the model
        for (int c = 0; c < 800; c++) begin
            bus.valid_PS   = ($urandom_range(0, 2) != 0);
            bus.data_in_PS = ($urandom_range(0, 4) == 0) ? COMMA_SYM : 8'($urandom);
            tick();
        end
        bus.valid_PS = 1'b0;
        repeat (16) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_paralelo_serial_tx
